// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for one master of the data-memory arbiter.
// The master drives the request side; the arbiter returns grant and completion.
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic        lock;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the word-addressed data memory, with
// bounded lock bursts and registered read return one cycle after grant.
module dmem_arbiter #(
  parameter int MAX_LOCK = 8,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  dmem_arbiter_if.slave      m0,
  dmem_arbiter_if.slave      m1,
  output logic               mem_ce,
  output logic               mem_we,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state, state_nxt;
  logic             last, last_nxt;
  logic [CNT_W-1:0] lock_cnt, cnt_nxt, cnt_inc;
  logic             gnt0, gnt1;
  logic             cont;
  logic             arb_last;
  logic             sel_lock;

  // Grant selection: a live owner keeps the memory, otherwise round robin.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    cont     = 1'b0;
    arb_last = last;
    if (state == OWN0 && m0.req) begin
      gnt0 = 1'b1;
      cont = 1'b1;
    end else if (state == OWN1 && m1.req) begin
      gnt1 = 1'b1;
      cont = 1'b1;
    end else begin
      if (state == OWN0)      arb_last = 1'b0;
      else if (state == OWN1) arb_last = 1'b1;
      if (m0.req && m1.req) begin
        gnt0 = arb_last;
        gnt1 = ~arb_last;
      end else begin
        gnt0 = m0.req;
        gnt1 = m1.req;
      end
    end
  end

  // A burst count only carries over when the owner is granted again;
  // any fresh grant starts counting from one.
  always_comb begin
    state_nxt = IDLE;
    cnt_nxt   = '0;
    last_nxt  = last;
    sel_lock  = gnt1 ? m1.lock : m0.lock;
    cnt_inc   = (cont ? lock_cnt : '0) + CNT_W'(1);
    if (gnt0 || gnt1) begin
      last_nxt = gnt1;
      if (sel_lock && (int'(cnt_inc) < MAX_LOCK)) begin
        state_nxt = gnt1 ? OWN1 : OWN0;
        cnt_nxt   = cnt_inc;
      end
    end
  end

  always_comb begin
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_ce    = 1'b1;
      mem_we    = m0.we;
      mem_addr  = m0.addr;
      mem_wdata = m0.wdata;
    end else if (gnt1) begin
      mem_ce    = 1'b1;
      mem_we    = m1.we;
      mem_addr  = m1.addr;
      mem_wdata = m1.wdata;
    end
  end

  assign m0.gnt = gnt0;
  assign m1.gnt = gnt1;

  // Grant cycle -> completion cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      lock_cnt  <= '0;
      m0.rvalid <= 1'b0;
      m1.rvalid <= 1'b0;
      m0.rdata  <= '0;
      m1.rdata  <= '0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      lock_cnt  <= cnt_nxt;
      m0.rvalid <= gnt0;
      m1.rvalid <= gnt1;
      m0.rdata  <= (gnt0 && !m0.we) ? mem_rdata : '0;
      m1.rdata  <= (gnt1 && !m1.we) ? mem_rdata : '0;
    end
  end

endmodule
